// File: rtl/handshake_responder_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : handshake_pkg
//  Purpose  : Shared types for the req/ack pull-protocol responder and the
//             initiator-side collector (FSM encoding, pointer-width helper).
//  Revision : 1.0  initial release
// ============================================================================
package handshake_pkg;

   // Responder FSM encoding; values are fixed so both ends agree on them.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      GAP  = 2'd2
   } state_e;

   // Pointer width for a power-of-two FIFO. The extra MSB tells full from
   // empty once the pointers wrap.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : handshake_pkg
`default_nettype wire

// File: rtl/handshake_responder_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_mem
//  Purpose  : Single-clock circular buffer with an asynchronous read port at
//             the read pointer, plus occupancy flags derived from the
//             registered pointers.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_mem
   import handshake_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en_i,
   input  logic [DATA_WIDTH-1:0]   wr_data_i,
   input  logic                    rd_en_i,
   output logic [DATA_WIDTH-1:0]   rd_data_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_width(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  w_push;
   logic                  w_pop;

   // Pointers wrap modulo 2*DEPTH; equal LSBs with differing MSBs means full.
   assign level_o   = wr_ptr_q - rd_ptr_q;
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
   assign w_push    = wr_en_i & ~full_o;
   assign w_pop     = rd_en_i & ~empty_o;
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   // Next-pointer computation; acceptance is judged on pre-edge flags.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
   end

   // Pointer registers; reset empties the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (w_push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/handshake_responder_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : handshake_responder_fifo
//  Purpose  : Buffered responder for the req/ack pull protocol. Words pushed
//             by a local writer are delivered one per ack, with a minimum
//             spacing of ACK_GAP+1 cycles between acks.
//  Revision : 1.0  initial release
// ============================================================================
module handshake_responder_fifo
   import handshake_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int ACK_GAP    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow,
   input  logic                    req,
   output logic                    ack,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic [31:0]             count
);

   // Gap counter only has to hold ACK_GAP-1.
   localparam int GW = (ACK_GAP > 1) ? $clog2(ACK_GAP) : 1;

   state_e                state_q, state_d;
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [31:0]           count_q, count_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic                  ovf_q, ovf_d;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_rd_data;

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_data),
      .rd_en_i   (w_pop),
      .rd_data_o (w_rd_data),
      .full_o    (full),
      .empty_o   (empty),
      .level_o   (level)
   );

   // Responder next-state: pop on req in IDLE, hold ack one cycle, then
   // enforce the idle gap before returning to IDLE.
   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      dout_d  = dout_q;
      count_d = count_q;
      gap_d   = gap_q;
      w_pop   = 1'b0;
      ovf_d   = ovf_q | (wr_en & full);
      case (state_q)
         IDLE: begin
            if (req && !empty) begin
               w_pop   = 1'b1;
               ack_d   = 1'b1;
               dout_d  = w_rd_data;
               count_d = count_q + 32'd1;
               state_d = ACK;
            end
         end
         ACK: begin
            if (ACK_GAP == 1) begin
               state_d = IDLE;
            end else begin
               gap_d   = GW'(ACK_GAP - 1);
               state_d = GAP;
            end
         end
         GAP: begin
            gap_d = gap_q - GW'(1);
            if (gap_q <= GW'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Responder state and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         dout_q  <= '0;
         count_q <= '0;
         gap_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         dout_q  <= dout_d;
         count_q <= count_d;
         gap_q   <= gap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ack      = ack_q;
   assign dout     = dout_q;
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule : handshake_responder_fifo
`default_nettype wire

// File: tb/tb_handshake_responder_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_handshake_responder_fifo
//  Purpose  : Self-checking bench for handshake_responder_fifo. Instance 0
//             uses ACK_GAP=1, instance 1 uses ACK_GAP=3; both are compared
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_handshake_responder_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int LW    = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]         rst, wr_en, req;
   logic [1:0][DW-1:0] wr_data;
   logic [1:0]         full, empty, overflow, ack;
   logic [1:0][LW-1:0] level;
   logic [1:0][DW-1:0] dout;
   logic [1:0][31:0]   count;

   int n_cmp = 0;
   int n_bad = 0;

   handshake_responder_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ACK_GAP(1)) dut_g1 (
      .clk(clk), .rst(rst[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
      .full(full[0]), .empty(empty[0]), .level(level[0]), .overflow(overflow[0]),
      .req(req[0]), .ack(ack[0]), .dout(dout[0]), .count(count[0]));

   handshake_responder_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ACK_GAP(3)) dut_g3 (
      .clk(clk), .rst(rst[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
      .full(full[1]), .empty(empty[1]), .level(level[1]), .overflow(overflow[1]),
      .req(req[1]), .ack(ack[1]), .dout(dout[1]), .count(count[1]));

   // Reference model: a word queue plus "edges since last ack".
   int unsigned   gapv [2] = '{1, 3};
   logic [DW-1:0] mq [2][$];
   logic          m_ack [2];
   logic [DW-1:0] m_dout [2];
   logic [31:0]   m_count [2];
   logic          m_ovf [2];
   int            since [2];
   bit            m_full_pre, m_pop;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst[k]) begin
            mq[k].delete();
            m_ack[k]   = 1'b0;
            m_dout[k]  = '0;
            m_count[k] = '0;
            m_ovf[k]   = 1'b0;
            since[k]   = gapv[k] + 1;
         end else begin
            m_full_pre = (mq[k].size() == DEPTH);
            if (since[k] < 1000) since[k]++;
            m_pop = req[k] && (mq[k].size() > 0) && (since[k] > int'(gapv[k]));
            m_ack[k] = m_pop;
            if (m_pop) begin
               m_dout[k]  = mq[k].pop_front();
               m_count[k] = m_count[k] + 32'd1;
               since[k]   = 0;
            end
            if (wr_en[k]) begin
               if (!m_full_pre) mq[k].push_back(wr_data[k]);
               else             m_ovf[k] = 1'b1;
            end
         end
      end
   end

   task automatic do_reset(input int k);
      rst[k] = 1'b1; wr_en[k] = 1'b0; req[k] = 1'b0;
      @(negedge clk);
      rst[k] = 1'b0;
   endtask

   task automatic push(input int k, input logic [DW-1:0] d);
      wr_en[k] = 1'b1; wr_data[k] = d;
      @(negedge clk);
      wr_en[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 2'b11; wr_en = '0; req = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      rst = 2'b00;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (ack[k] !== 1'b0 || dout[k] !== '0 || count[k] !== 32'd0 || level[k] !== 4'd0 ||
             empty[k] !== 1'b1 || full[k] !== 1'b0 || overflow[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state inst%0d: ack=%b dout=%h count=%0d level=%0d empty=%b full=%b ovf=%b, expected 0 0 0 0 1 0 0",
                     k, ack[k], dout[k], count[k], level[k], empty[k], full[k], overflow[k]);
         end
      end
      req = 2'b11;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ack[k] !== 1'b0 || dout[k] !== '0 || count[k] !== 32'd0 || empty[k] !== 1'b1) begin
               n_bad++;
               $display("FAIL idle_req inst%0d cyc%0d: ack=%b dout=%h count=%0d empty=%b, expected 0 0 0 1",
                        k, c, ack[k], dout[k], count[k], empty[k]);
            end
         end
      end
      req = 2'b00;
   endtask

   task automatic test_stream();
      logic [DW-1:0] sent[$];
      logic [DW-1:0] got[$];
      int last = -100;
      do_reset(0);
      req[0] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c < 5) begin
            wr_en[0] = 1'b1; wr_data[0] = $urandom; sent.push_back(wr_data[0]);
         end else wr_en[0] = 1'b0;
         @(negedge clk);
         n_cmp++;
         if (ack[0] !== m_ack[0] || dout[0] !== m_dout[0] || count[0] !== m_count[0] ||
             level[0] !== LW'(mq[0].size())) begin
            n_bad++;
            $display("FAIL stream_cycle cyc%0d: ack=%b dout=%h count=%0d level=%0d, expected %b %h %0d %0d",
                     c, ack[0], dout[0], count[0], level[0], m_ack[0], m_dout[0], m_count[0], mq[0].size());
         end
         if (ack[0] === 1'b1) begin
            got.push_back(dout[0]);
            n_cmp++;
            if (c - last < 2) begin
               n_bad++;
               $display("FAIL stream_spacing: gap=%0d cycles, expected >=2", c - last);
            end
            last = c;
         end
      end
      req[0] = 1'b0;
      n_cmp++;
      if (got.size() != 5) begin
         n_bad++;
         $display("FAIL stream_len: got %0d words, expected 5", got.size());
      end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== sent[i]) begin
            n_bad++;
            $display("FAIL stream_order[%0d]: got %h, expected %h", i, got[i], sent[i]);
         end
      end
      n_cmp++;
      if (count[0] !== 32'd5 || empty[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL stream_end: count=%0d empty=%b, expected 5 1", count[0], empty[0]);
      end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] sent[$];
      logic [DW-1:0] got[$];
      do_reset(0);
      for (int i = 0; i < 9; i++) begin
         sent.push_back($urandom);
         push(0, sent[i]);
         if (i == 7) begin
            n_cmp++;
            if (full[0] !== 1'b1 || level[0] !== 4'd8 || overflow[0] !== 1'b0) begin
               n_bad++;
               $display("FAIL fill8: full=%b level=%0d ovf=%b, expected 1 8 0", full[0], level[0], overflow[0]);
            end
         end
      end
      n_cmp++;
      if (full[0] !== 1'b1 || level[0] !== 4'd8 || overflow[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL overflow_set: full=%b level=%0d ovf=%b, expected 1 8 1", full[0], level[0], overflow[0]);
      end
      req[0] = 1'b1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (ack[0] === 1'b1) got.push_back(dout[0]);
      end
      req[0] = 1'b0;
      n_cmp++;
      if (got.size() != 8 || count[0] !== 32'd8 || empty[0] !== 1'b1 || overflow[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL overflow_drain: words=%0d count=%0d empty=%b ovf=%b, expected 8 8 1 1",
                  got.size(), count[0], empty[0], overflow[0]);
      end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== sent[i]) begin
            n_bad++;
            $display("FAIL overflow_order[%0d]: got %h, expected %h", i, got[i], sent[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] got[$];
      do_reset(0);
      for (int r = 0; r < 3; r++) begin
         got.delete();
         for (int i = 0; i < 6; i++) push(0, DW'(100 + r * 6 + i));
         req[0] = 1'b1;
         for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (ack[0] === 1'b1) got.push_back(dout[0]);
         end
         req[0] = 1'b0;
         n_cmp++;
         if (got.size() != 6 || level[0] !== 4'd0) begin
            n_bad++;
            $display("FAIL wrap_round%0d: words=%0d level=%0d, expected 6 0", r, got.size(), level[0]);
         end
         for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== DW'(100 + r * 6 + i)) begin
               n_bad++;
               $display("FAIL wrap_order r%0d[%0d]: got %0d, expected %0d", r, i, got[i], 100 + r * 6 + i);
            end
         end
      end
      n_cmp++;
      if (count[0] !== 32'd18) begin
         n_bad++;
         $display("FAIL wrap_count: got %0d, expected 18", count[0]);
      end
   endtask

   task automatic test_gap();
      logic [DW-1:0] sent[$];
      logic [DW-1:0] got[$];
      logic prev = 1'b0;
      int last = -100;
      int n_win;
      do_reset(1);
      for (int i = 0; i < 4; i++) begin
         sent.push_back($urandom);
         push(1, sent[i]);
      end
      for (int w = 0; w < 4; w++) begin
         n_win = 0;
         for (int c = 0; c < 7; c++) begin
            req[1] = (c == 0);
            @(negedge clk);
            n_cmp++;
            if (ack[1] !== m_ack[1] || dout[1] !== m_dout[1]) begin
               n_bad++;
               $display("FAIL gap_model w%0d c%0d: ack=%b dout=%h, expected %b %h",
                        w, c, ack[1], dout[1], m_ack[1], m_dout[1]);
            end
            if (ack[1] === 1'b1) begin
               n_win++;
               got.push_back(dout[1]);
               n_cmp++;
               if (prev === 1'b1 || (w * 7 + c) - last < 4) begin
                  n_bad++;
                  $display("FAIL gap_spacing: prev_ack=%b spacing=%0d, expected 0 and >=4", prev, (w * 7 + c) - last);
               end
               last = w * 7 + c;
            end
            prev = ack[1];
         end
         n_cmp++;
         if (n_win != 1) begin
            n_bad++;
            $display("FAIL gap_window%0d: acks=%0d, expected 1", w, n_win);
         end
      end
      req[1] = 1'b0;
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== sent[i]) begin
            n_bad++;
            $display("FAIL gap_order[%0d]: got %h, expected %h", i, got[i], sent[i]);
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset(0);
      for (int i = 0; i < 3; i++) push(0, $urandom);
      req[0] = 1'b1; wr_en[0] = 1'b1; wr_data[0] = $urandom;
      @(negedge clk);
      req[0] = 1'b0; wr_en[0] = 1'b0;
      n_cmp++;
      if (ack[0] !== 1'b1 || level[0] !== 4'd3 || overflow[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL push_pop_level: ack=%b level=%0d ovf=%b, expected 1 3 0", ack[0], level[0], overflow[0]);
      end
      for (int i = 0; i < 5; i++) push(0, $urandom);
      req[0] = 1'b1; wr_en[0] = 1'b1; wr_data[0] = $urandom;
      @(negedge clk);
      req[0] = 1'b0; wr_en[0] = 1'b0;
      n_cmp++;
      if (ack[0] !== 1'b1 || level[0] !== 4'd7 || overflow[0] !== 1'b1 || full[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL full_push_pop: ack=%b level=%0d ovf=%b full=%b, expected 1 7 1 0",
                  ack[0], level[0], overflow[0], full[0]);
      end
   endtask

   task automatic test_random();
      bit fill;
      do_reset(0);
      do_reset(1);
      for (int c = 0; c < 400; c++) begin
         fill = (c < 200);
         for (int k = 0; k < 2; k++) begin
            wr_en[k]   = ($urandom_range(0, 3) < (fill ? 3 : 1));
            req[k]     = ($urandom_range(0, 3) < (fill ? 1 : 3));
            wr_data[k] = $urandom;
         end
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ack[k] !== m_ack[k] || dout[k] !== m_dout[k] || count[k] !== m_count[k] ||
                level[k] !== LW'(mq[k].size()) || full[k] !== (mq[k].size() == DEPTH) ||
                empty[k] !== (mq[k].size() == 0) || overflow[k] !== m_ovf[k]) begin
               n_bad++;
               $display("FAIL random inst%0d cyc%0d: ack=%b dout=%h cnt=%0d lvl=%0d full=%b empty=%b ovf=%b, expected %b %h %0d %0d %b %b %b",
                        k, c, ack[k], dout[k], count[k], level[k], full[k], empty[k], overflow[k],
                        m_ack[k], m_dout[k], m_count[k], mq[k].size(), mq[k].size() == DEPTH,
                        mq[k].size() == 0, m_ovf[k]);
            end
         end
      end
      wr_en = '0; req = '0;
   endtask

   task automatic test_reset_mid();
      bit seen;
      do_reset(0);
      for (int i = 0; i < 4; i++) push(0, $urandom);
      req[0] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (ack[0] === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL resetmid_first_ack: ack=0 after 10 cycles, expected 1");
      end
      rst[0] = 1'b1; req[0] = 1'b0;
      @(negedge clk);
      rst[0] = 1'b0;
      n_cmp++;
      if (level[0] !== 4'd0 || count[0] !== 32'd0 || ack[0] !== 1'b0 || empty[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL resetmid_state: level=%0d count=%0d ack=%b empty=%b, expected 0 0 0 1",
                  level[0], count[0], ack[0], empty[0]);
      end
      push(0, 32'hAB);
      req[0] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (ack[0] === 1'b1) seen = 1'b1;
      end
      req[0] = 1'b0;
      n_cmp++;
      if (!seen || dout[0] !== 32'hAB || count[0] !== 32'd1) begin
         n_bad++;
         $display("FAIL resetmid_new_word: seen=%b dout=%h count=%0d, expected 1 000000ab 1",
                  seen, dout[0], count[0]);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_overflow();
      test_wrap();
      test_gap();
      test_simultaneous();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_handshake_responder_fifo
`default_nettype wire
